branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: LINK_EN, default 0; when 1, a taken branch also writes the return address.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to execute one branch; sampled only in IDLE.
REQ-005 flush  input  1  synchronous abort of any branch in progress.
REQ-006 cond  input  2  condition: 00 always, 01 zero flag set, 10 negative flag set, 11 never.
REQ-007 offset  input  6  signed two's-complement branch displacement.
REQ-008 pc_in  input  8  address of the branch instruction.
REQ-009 zero  input  1  ALU zero flag.
REQ-010 neg  input  1  ALU negative flag.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 pc_out  output  8  next program-counter value; registered.
REQ-013 pc_we  output  1  one-cycle program-counter write strobe.
REQ-014 taken  output  1  condition result; valid while pc_we is high.
REQ-015 done  output  1  one-cycle completion pulse, coincident with pc_we.
REQ-016 link_out  output  8  return address (pc_in+1); registered.
REQ-017 link_we  output  1  one-cycle link write strobe; constant 0 when LINK_EN=0.

Function
REQ-018 States: IDLE, EVAL, CALC, COMMIT; encoding is free.
REQ-019 In IDLE with start=1 and flush=0: capture offset, cond, pc_in, zero and neg into internal registers, then go to EVAL.
REQ-020 In EVAL: compute taken from the captured cond and flags; if taken, go to CALC, else go to COMMIT with target=pc_in+1.
REQ-021 In CALC: target = pc_in + 1 + sext8(offset); sext8 replicates offset[5] into bits 7:6; addition is modulo 256 with no overflow flag; then go to COMMIT.
REQ-022 In COMMIT: pc_out=target, pc_we=1 and done=1 for exactly one cycle; if LINK_EN=1 and taken=1, also link_out=pc_in+1 and link_we=1; then go to IDLE.
REQ-023 Latency, counted from the start-sampled edge as cycle 0: pc_we is high in cycle 3 when taken and in cycle 2 when not taken.
REQ-024 start while busy=1 is ignored, with no queuing; a new start is accepted in the cycle after COMMIT.
REQ-025 Flags are sampled only at start; later flag changes do not affect the branch in flight.
REQ-026 flush=1 in any state: next state is IDLE, with no pc_we, done or link_we pulse; flush in COMMIT suppresses that cycle's strobes combinationally.
REQ-027 flush and start high together in IDLE: flush wins and start is not accepted.
REQ-028 cond=11 is never taken and follows the not-taken path to pc_in+1.
REQ-029 pc_out and link_out hold their last values between commits.

Reset
REQ-030 rst_n low forces IDLE immediately, with no clock edge required, including mid-operation.
REQ-031 Under reset: busy=0, pc_we=0, done=0, taken=0, link_we=0, pc_out=8'h00, link_out=8'h00, and all captured registers are 0.
REQ-032 After rst_n deasserts, the first start is accepted on the next rising edge.

Verification
REQ-033 pc_in=8'h10, offset=6'b111110 (-2), cond=00, start pulse -> cycle 3: pc_out=8'h0F, pc_we=done=taken=1.
REQ-034 pc_in=8'hFF, offset=6'b000001, cond=00 -> pc_out=8'h01 (wrap-around); pc_in=8'h00, offset=6'b100000 (-32) -> pc_out=8'hE1.
REQ-035 pc_in=8'h20, cond=01, zero=0 -> cycle 2: pc_out=8'h21, taken=0; repeat with zero=1, offset=6'b000011 -> cycle 3: pc_out=8'h24.
REQ-036 Second start pulsed in cycle 1 of a branch in flight -> exactly one pc_we pulse; flag toggles after start have no effect.
REQ-037 flush in CALC -> no pc_we, busy=0 next cycle; rst_n low in EVAL -> busy=0 and pc_out=8'h00 before the next edge.
REQ-038 LINK_EN=1, pc_in=8'h40, taken -> link_out=8'h41 with link_we coincident with pc_we; not taken -> link_we stays 0.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: four-state conditional branch sequencer.
// Captures a branch request (condition, flags, displacement, pc) in IDLE,
// evaluates the condition in EVAL, forms the taken target in CALC and
// presents the result with single-cycle strobes in COMMIT.
// Not-taken branches skip CALC, so they commit one cycle earlier.
module branch_ctrl #(
  parameter bit LINK_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       flush,
  input  logic [1:0] cond,
  input  logic [5:0] offset,
  input  logic [7:0] pc_in,
  input  logic       zero,
  input  logic       neg,
  output logic       busy,
  output logic [7:0] pc_out,
  output logic       pc_we,
  output logic       taken,
  output logic       done,
  output logic [7:0] link_out,
  output logic       link_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    CALC   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Request snapshot, frozen for the whole branch so later flag or input
  // changes cannot disturb the branch in flight.
  logic [5:0] off_r;
  logic [1:0] cond_r;
  logic [7:0] pc_r;
  logic       zero_r;
  logic       neg_r;
  logic       taken_r;

  logic [7:0] pc_out_r;
  logic [7:0] link_out_r;

  logic       cond_true;
  logic [7:0] pc_inc;
  logic [7:0] target_taken;
  logic       capture;
  logic       load_nt;
  logic       load_t;
  logic       commit;

  // Condition decode from the captured condition code and flags.
  always_comb begin
    cond_true = 1'b0;
    case (cond_r)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = zero_r;
      2'b10:   cond_true = neg_r;
      2'b11:   cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Fall-through address and sign-extended taken target, both modulo 256.
  always_comb begin
    pc_inc       = pc_r + 8'd1;
    target_taken = pc_inc + {{2{off_r[5]}}, off_r};
  end

  // Next-state and load-enable decode; flush overrides every state and
  // therefore also blocks any load or commit strobe in the same cycle.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    load_nt    = 1'b0;
    load_t     = 1'b0;
    commit     = 1'b0;
    if (flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            capture    = 1'b1;
            next_state = EVAL;
          end else begin
            next_state = IDLE;
          end
        end
        EVAL: begin
          if (cond_true) begin
            next_state = CALC;
          end else begin
            load_nt    = 1'b1;
            next_state = COMMIT;
          end
        end
        CALC: begin
          load_t     = 1'b1;
          next_state = COMMIT;
        end
        COMMIT: begin
          commit     = 1'b1;
          next_state = IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture at acceptance time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r  <= 6'd0;
      cond_r <= 2'd0;
      pc_r   <= 8'd0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
    end else if (capture) begin
      off_r  <= offset;
      cond_r <= cond;
      pc_r   <= pc_in;
      zero_r <= zero;
      neg_r  <= neg;
    end
  end

  // Condition result, cleared on a new request and set during EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_r <= 1'b0;
    end else if (capture) begin
      taken_r <= 1'b0;
    end else if (state == EVAL && !flush) begin
      taken_r <= cond_true;
    end
  end

  // Program-counter output register: loaded on the way into COMMIT and held
  // otherwise, so it keeps the last committed target between branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out_r <= 8'h00;
    end else if (load_nt) begin
      pc_out_r <= pc_inc;
    end else if (load_t) begin
      pc_out_r <= target_taken;
    end
  end

  // Return-address register: only a taken branch with linking enabled
  // updates it; the load happens in CALC so it is stable during COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_out_r <= 8'h00;
    end else if (LINK_EN && load_t) begin
      link_out_r <= pc_inc;
    end
  end

  // Output decode: strobes are gated by flush through the commit term.
  always_comb begin
    busy     = (state != IDLE);
    pc_out   = pc_out_r;
    link_out = link_out_r;
    pc_we    = commit;
    done     = commit;
    taken    = commit & taken_r;
    link_we  = LINK_EN ? (commit & taken_r) : 1'b0;
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a default instance and a linking
// instance see identical stimulus; the driver queues expected commits and a
// negedge monitor pops and checks them whenever a pc_we strobe appears.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] cond = 2'd0;
  logic [5:0] offset = 6'd0;
  logic [7:0] pc_in = 8'd0;
  logic       zero = 1'b0;
  logic       neg = 1'b0;

  logic       busy0, pc_we0, taken0, done0, link_we0;
  logic [7:0] pc_out0, link_out0;
  logic       busy1, pc_we1, taken1, done1, link_we1;
  logic [7:0] pc_out1, link_out1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] pc;
    logic       tk;
    logic [7:0] link;
    int         cyc;
  } exp_t;
  exp_t q[$];

  branch_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .cond(cond),
    .offset(offset), .pc_in(pc_in), .zero(zero), .neg(neg),
    .busy(busy0), .pc_out(pc_out0), .pc_we(pc_we0), .taken(taken0),
    .done(done0), .link_out(link_out0), .link_we(link_we0)
  );

  branch_ctrl #(.LINK_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .cond(cond),
    .offset(offset), .pc_in(pc_in), .zero(zero), .neg(neg),
    .busy(busy1), .pc_out(pc_out1), .pc_we(pc_we1), .taken(taken1),
    .done(done1), .link_out(link_out1), .link_we(link_we1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pc_we strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (pc_we0 || pc_we1)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pc_we: pc_we0=%0b pc_we1=%0b with nothing pending", pc_we0, pc_we1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_cycle", cyc, e.cyc);
        chk("pc_we0", int'(pc_we0), 1);
        chk("pc_we1", int'(pc_we1), 1);
        chk("done0", int'(done0), 1);
        chk("done1", int'(done1), 1);
        chk("pc_out0", int'(pc_out0), int'(e.pc));
        chk("pc_out1", int'(pc_out1), int'(e.pc));
        chk("taken0", int'(taken0), int'(e.tk));
        chk("taken1", int'(taken1), int'(e.tk));
        chk("link_we0", int'(link_we0), 0);
        chk("link_we1", int'(link_we1), int'(e.tk));
        if (e.tk) chk("link_out1", int'(link_out1), int'(e.link));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: busy0=%0b busy1=%0b after 10 cycles", busy0, busy1);
  endtask

  task automatic issue(input logic [7:0] pc, input logic [5:0] off, input logic [1:0] c,
                       input logic z, input logic n,
                       input logic [7:0] epc, input logic etk, input logic [7:0] elink);
    @(negedge clk);
    pc_in = pc; offset = off; cond = c; zero = z; neg = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q.push_back('{epc, etk, elink, cyc + (etk ? 2 : 1)});
    wait_idle();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_pc_we", int'(pc_we0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_taken", int'(taken1), 0);
    chk("rst_link_we", int'(link_we1), 0);
    chk("rst_pc_out", int'(pc_out1), 0);
    chk("rst_link_out", int'(link_out1), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: pc, offset, cond, zero, neg -> pc_out, taken, link
    issue(8'h10, 6'b111110, 2'b00, 1'b0, 1'b0, 8'h0F, 1'b1, 8'h11);
    issue(8'hFF, 6'b000001, 2'b00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00);
    issue(8'h00, 6'b100000, 2'b00, 1'b0, 1'b0, 8'hE1, 1'b1, 8'h01);
    issue(8'h20, 6'b000011, 2'b01, 1'b0, 1'b0, 8'h21, 1'b0, 8'h00);
    issue(8'h20, 6'b000011, 2'b01, 1'b1, 1'b0, 8'h24, 1'b1, 8'h21);
    issue(8'h40, 6'b000101, 2'b10, 1'b0, 1'b1, 8'h46, 1'b1, 8'h41);
    issue(8'h40, 6'b000101, 2'b10, 1'b0, 1'b0, 8'h41, 1'b0, 8'h00);
    issue(8'h7F, 6'b000001, 2'b11, 1'b1, 1'b1, 8'h80, 1'b0, 8'h00);

    // Second start while busy plus flag toggles: one commit from the first request
    @(negedge clk);
    pc_in = 8'h30; offset = 6'b111111; cond = 2'b01; zero = 1'b1; neg = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{8'h30, 1'b1, 8'h31, cyc + 2});
    pc_in = 8'h90; zero = 1'b0; neg = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    zero = 1'b1;
    wait_idle();

    // Flush in CALC: no strobe, idle next cycle, pc_out holds
    @(negedge clk);
    pc_in = 8'h10; offset = 6'b000001; cond = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("calc_busy", int'(busy0), 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_calc_busy0", int'(busy0), 0);
    chk("flush_calc_busy1", int'(busy1), 0);
    chk("flush_calc_pc_hold", int'(pc_out1), 8'h30);

    // Flush and start together in IDLE: flush wins
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", int'(busy0), 0);

    // Flush in COMMIT: strobes suppressed combinationally
    @(negedge clk);
    pc_in = 8'h60; cond = 2'b11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_commit_pc_we", int'(pc_we0), 0);
    chk("flush_commit_done", int'(done1), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_commit_busy", int'(busy1), 0);

    // Asynchronous reset during EVAL
    @(negedge clk);
    pc_in = 8'h10; offset = 6'b111110; cond = 2'b00; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("eval_busy", int'(busy1), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy1), 0);
    chk("async_rst_pc_out0", int'(pc_out0), 0);
    chk("async_rst_pc_out1", int'(pc_out1), 0);
    chk("async_rst_link_out", int'(link_out1), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First start after reset is accepted
    issue(8'h05, 6'b011111, 2'b00, 1'b0, 1'b0, 8'h25, 1'b1, 8'h06);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
